// File: rtl/aes_enc_round_unit.sv
`timescale 1ns/1ps
// aes_enc_round_unit
// Forward AES round datapath for a state that has already been through SubBytes:
// ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
// Two-stage elastic pipeline with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   in_valid     upstream beat present (state_in, round_key, final_round)
//   in_ready     unit accepts the input beat this cycle
//   state_in     post-SubBytes state, byte k = bits [8k+:8], row k%4, column k/4
//   round_key    round key, same byte layout
//   final_round  1 = omit MixColumns for this beat
//   out_valid    state_out holds a completed round
//   out_ready    downstream accepts state_out
//   state_out    round result, same byte layout
//   out_count    completed output beats, modulo 2^CNT_W
//   busy         either pipeline stage holds a valid beat
module aes_enc_round_unit #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     state_in,
    input  logic [0:127]     round_key,
    input  logic             final_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     state_out,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_column(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    logic [0:127] shifted;
    logic [0:127] mixed;
    logic [0:127] s1_next;

    always_comb begin
        shifted = '0;
        mixed   = '0;
        // Row r of the output takes column (c+r) mod 4 of the input.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(r+4*c) +: 8] = state_in[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
        end
        s1_next = final_round ? shifted : mixed;
    end

    logic         s1_valid;
    logic [0:127] s1_data;
    logic [0:127] s1_key;
    logic         s2_load;
    logic         in_fire;
    logic         out_fire;

    // Stage 2 moves when it is empty or being drained; stage 1 can refill in
    // the same cycle, so full throughput needs no bubble.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = s1_valid || out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_key   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_data  <= s1_next;
                s1_key   <= round_key;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            state_out <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                state_out <= s1_data ^ s1_key;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_fire) begin
            out_count <= out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_enc_round_unit.sv
`timescale 1ns/1ps
// tb_aes_enc_round_unit
// Directed self-checking bench for aes_enc_round_unit: reset state, latency,
// known-answer vectors (FIPS-197 round, MixColumns, ShiftRows, key XOR),
// backpressure, full throughput with counter wrap, and asynchronous reset.
module tb_aes_enc_round_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:127]     state_in;
    logic [0:127]     round_key;
    logic             final_round;
    logic             out_valid;
    logic             out_ready;
    logic [0:127]     state_out;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    aes_enc_round_unit #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .round_key  (round_key),
        .final_round(final_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out),
        .out_count  (out_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int n_out    = 0;

    logic [0:127] vin  [5];
    logic [0:127] vkey [5];
    logic         vfin [5];
    logic [0:127] vexp [5];
    logic [0:127] expq [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, score transfers, advance to just after the edge.
    task automatic cycle(input logic v, input int idx, input logic ordy, output logic acc);
        in_valid    = v;
        state_in    = vin[idx];
        round_key   = vkey[idx];
        final_round = vfin[idx];
        out_ready   = ordy;
        #1;
        acc = in_valid && in_ready;
        if (acc) expq.push_back(vexp[idx]);
        if (out_valid && out_ready) begin
            n_out++;
            check_eq("out_has_beat", expq.size() > 0, 1);
            if (expq.size() > 0) check_eq("out_data", state_out, expq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 10 && expq.size() > 0; k++) cycle(1'b0, 0, 1'b1, acc);
        check_eq("drain_empty", expq.size(), 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   b;
        int   n_before;
        int   drops;

        // Byte order is column-major: byte k is row k%4, column k/4.
        vin[0]  = 128'hd42711aee0bf98f1b8b45de51e415230;
        vkey[0] = 128'ha0fafe1788542cb123a339392a6c7605;
        vfin[0] = 1'b0;
        vexp[0] = 128'ha49c7ff2689f352b6b5bea43026a5049;
        vin[1]  = 128'hdb135345db135345db135345db135345;
        vkey[1] = '0;
        vfin[1] = 1'b0;
        vexp[1] = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;
        vin[2]  = 128'hdb135345db135345db135345db135345;
        vkey[2] = '0;
        vfin[2] = 1'b1;
        vexp[2] = 128'hdb135345db135345db135345db135345;
        vin[3]  = 128'h000102030405060708090a0b0c0d0e0f;
        vkey[3] = '0;
        vfin[3] = 1'b1;
        vexp[3] = 128'h00050a0f04090e03080d02070c01060b;
        vin[4]  = 128'h000102030405060708090a0b0c0d0e0f;
        vkey[4] = '1;
        vfin[4] = 1'b1;
        vexp[4] = 128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4;

        state_in    = '0;
        round_key   = '0;
        final_round = 1'b0;
        do_reset();

        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_count", out_count, 0);
        check_eq("rst_state_out", state_out, 0);

        // FIPS-197 round 1 with exact 2-cycle latency.
        in_valid    = 1'b1;
        state_in    = vin[0];
        round_key   = vkey[0];
        final_round = vfin[0];
        out_ready   = 1'b1;
        #1;
        check_eq("lat_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("lat_valid_c1", out_valid, 0);
        check_eq("lat_busy_c1", busy, 1);
        @(posedge clk);
        #1;
        check_eq("lat_valid_c2", out_valid, 1);
        check_eq("fips_round1", state_out, vexp[0]);
        check_eq("lat_count_c2", out_count, 0);
        @(posedge clk);
        #1;
        check_eq("lat_valid_c3", out_valid, 0);
        check_eq("fips_count", out_count, 1);
        check_eq("lat_busy_c3", busy, 0);

        // Interleaved mixed / final beats, back to back.
        for (int i = 1; i < 5; i++) cycle(1'b1, i, 1'b1, acc);
        drain();

        // Backpressure: only two beats fit while the output is stalled.
        n_before = n_out;
        n_acc    = 0;
        b        = 1;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, b, 1'b0, acc);
            if (acc) begin
                b++;
                n_acc++;
            end
        end
        check_eq("bp_accepted", n_acc, 2);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_held", state_out, vexp[1]);
        for (int k = 0; k < 20 && b <= 4; k++) begin
            cycle(1'b1, b, 1'b1, acc);
            if (acc) b++;
        end
        drain();
        check_eq("bp_delivered", n_out - n_before, 4);

        // Full throughput from reset, counter wraps at 16.
        do_reset();
        n_out = 0;
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, i % 5, 1'b1, acc);
            if (!acc) drops++;
        end
        check_eq("tp_ready_drops", drops, 0);
        drain();
        check_eq("tp_transfers", n_out, 20);
        check_eq("tp_count_wrap", out_count, 4);

        // Asynchronous reset with two beats in flight.
        cycle(1'b1, 0, 1'b0, acc);
        cycle(1'b1, 1, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_out_count", out_count, 0);
        check_eq("arst_state_out", state_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();

        // Fresh beat after reset still takes exactly 2 cycles.
        in_valid    = 1'b1;
        state_in    = vin[4];
        round_key   = vkey[4];
        final_round = vfin[4];
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("post_valid_c1", out_valid, 0);
        @(posedge clk);
        #1;
        check_eq("post_valid_c2", out_valid, 1);
        check_eq("post_data", state_out, vexp[4]);
        @(posedge clk);
        #1;
        check_eq("post_count", out_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
